// File: rtl/canon_pkg.sv
// Shared constants, FSM states and melody content for the canon note sequencer.
package canon_pkg;

  localparam int NOTE_W    = 6;
  localparam int LEN_W     = 3;
  localparam int DIV_W     = 11;
  localparam int STEP_W    = 6;
  localparam int NUM_NOTES = 48;
  localparam int ROM_DEPTH = 32;

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [LEN_W-1:0]  len;
  } melody_t;

  // {note, len}; note 0 is a rest, note 1 is G2
  localparam logic [NOTE_W+LEN_W-1:0] MELODY [ROM_DEPTH] = '{
    {6'd27, 3'd1}, {6'd15, 3'd0}, {6'd0,  3'd0}, {6'd20, 3'd1},
    {6'd24, 3'd0}, {6'd25, 3'd1}, {6'd27, 3'd1}, {6'd20, 3'd0},
    {6'd36, 3'd1}, {6'd34, 3'd1}, {6'd32, 3'd1}, {6'd31, 3'd1},
    {6'd29, 3'd1}, {6'd27, 3'd1}, {6'd29, 3'd1}, {6'd31, 3'd1},
    {6'd32, 3'd0}, {6'd31, 3'd0}, {6'd29, 3'd0}, {6'd27, 3'd0},
    {6'd25, 3'd0}, {6'd24, 3'd0}, {6'd22, 3'd0}, {6'd0,  3'd0},
    {6'd20, 3'd2}, {6'd22, 3'd0}, {6'd24, 3'd1}, {6'd15, 3'd0},
    {6'd17, 3'd0}, {6'd8,  3'd1}, {6'd1,  3'd2}, {6'd0,  3'd1}
  };

  // Steps beyond the stored melody play as short rests
  function automatic melody_t melody(input logic [STEP_W-1:0] idx);
    if (idx >= STEP_W'(ROM_DEPTH)) return '0;
    return melody_t'(MELODY[idx[4:0]]);
  endfunction

endpackage

// File: rtl/canon_sequencer_if.sv
// Control inputs and voice-stage outputs of the canon sequencer.
interface canon_sequencer_if;
  import canon_pkg::*;

  logic              enable;
  logic              restart;
  logic              octave_up;
  logic [DIV_W-1:0]  divider;
  logic [STEP_W-1:0] step;
  logic              note_on;
  logic              tick;

  modport master (
    output enable, restart, octave_up,
    input  divider, step, note_on, tick
  );

  modport slave (
    input  enable, restart, octave_up,
    output divider, step, note_on, tick
  );
endinterface

// File: rtl/note_period_rom.sv
// Note index to pwm_sample divider: round(50e6 / (256 * f_n)) - 1, rest -> 0.
module note_period_rom
  import canon_pkg::*;
(
  input  logic [NOTE_W-1:0] note,
  output logic [DIV_W-1:0]  period
);

  localparam logic [DIV_W-1:0] TABLE [NUM_NOTES] = '{
    11'd1992, 11'd1880, 11'd1775, 11'd1675, 11'd1581, 11'd1492,
    11'd1408, 11'd1329, 11'd1255, 11'd1184, 11'd1118, 11'd1055,
    11'd995,  11'd940,  11'd887,  11'd837,  11'd790,  11'd746,
    11'd704,  11'd664,  11'd627,  11'd592,  11'd558,  11'd527,
    11'd497,  11'd469,  11'd443,  11'd418,  11'd394,  11'd372,
    11'd351,  11'd332,  11'd313,  11'd295,  11'd279,  11'd263,
    11'd248,  11'd234,  11'd221,  11'd208,  11'd197,  11'd186,
    11'd175,  11'd165,  11'd156,  11'd147,  11'd139,  11'd131
  };

  logic [NOTE_W-1:0] idx;

  assign idx = note - NOTE_W'(1);

  always_comb begin
    period = '0;
    if (note != '0 && note <= NOTE_W'(NUM_NOTES)) period = TABLE[idx];
  end

endmodule

// File: rtl/canon_sequencer.sv
// Melody sequencer: walks the melody at a programmable tempo, drives the voice divider
// with an articulation gap per note, supports pause, restart and octave transposition.
module canon_sequencer
  import canon_pkg::*;
#(
  parameter int TICK_DIV       = 781250,
  parameter int TICKS_PER_UNIT = 8,
  parameter int GAP_TICKS      = 2,
  parameter int SEQ_LEN        = 32
) (
  input logic              clk,
  input logic              rst,
  canon_sequencer_if.slave bus
);

  localparam int PS_W  = $clog2(TICK_DIV);
  localparam int REM_W = $clog2((1 << LEN_W) * TICKS_PER_UNIT + 1);
  localparam logic [PS_W-1:0]   PS_MAX   = PS_W'(TICK_DIV - 1);
  localparam logic [REM_W-1:0]  REM_GAP  = REM_W'(GAP_TICKS);
  localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(SEQ_LEN - 1);

  state_t            state, state_n;
  logic [PS_W-1:0]   presc, presc_n;
  logic [REM_W-1:0]  remaining, remaining_n, rem_dec;
  logic [STEP_W-1:0] step, step_n;
  logic [DIV_W-1:0]  cur_div, cur_div_n;
  logic              cur_rest, cur_rest_n;
  logic [DIV_W-1:0]  divider, divider_n;
  logic              note_on, note_on_n;
  logic              tick, tick_n;

  melody_t           entry;
  logic [DIV_W-1:0]  base_div, oct_div;
  logic [DIV_W:0]    base_inc;
  logic              running, tick_evt, advance;

  assign entry = melody(step);

  note_period_rom u_rom (
    .note   (entry.note),
    .period (base_div)
  );

  // One octave up halves the period: ((d + 1) >> 1) - 1, kept 12 bits wide to avoid overflow
  assign base_inc = {1'b0, base_div} + (DIV_W + 1)'(1);
  assign oct_div  = base_inc[DIV_W:1] - DIV_W'(1);

  assign running  = (state == PLAY || state == GAP) && bus.enable;
  assign tick_evt = running && (presc == PS_MAX);
  assign rem_dec  = remaining - REM_W'(1);

  always_comb begin
    state_n     = state;
    presc_n     = presc;
    remaining_n = remaining;
    step_n      = step;
    cur_div_n   = cur_div;
    cur_rest_n  = cur_rest;
    advance     = 1'b0;

    if (running) presc_n = tick_evt ? '0 : presc + PS_W'(1);

    case (state)
      IDLE: if (bus.enable) state_n = LOAD;
      LOAD: begin
        remaining_n = REM_W'((int'(entry.len) + 1) * TICKS_PER_UNIT);
        cur_rest_n  = (entry.note == '0);
        cur_div_n   = (entry.note == '0) ? '0 : (bus.octave_up ? oct_div : base_div);
        presc_n     = '0;
        state_n     = PLAY;
      end
      PLAY: if (tick_evt) begin
        remaining_n = rem_dec;
        if (rem_dec == '0) advance = 1'b1;
        else if (rem_dec == REM_GAP && !cur_rest) state_n = GAP;
      end
      GAP: if (tick_evt) begin
        remaining_n = rem_dec;
        if (rem_dec == '0) advance = 1'b1;
      end
      default: state_n = IDLE;
    endcase

    if (advance) begin
      step_n  = (step == STEP_MAX) ? '0 : step + STEP_W'(1);
      state_n = LOAD;
    end

    // Restart overrides any tick or step advance in the same cycle
    if (bus.restart) begin
      step_n  = '0;
      presc_n = '0;
      state_n = bus.enable ? LOAD : IDLE;
    end

    // Outputs are registered from next-state values; a pause silences but keeps cur_div
    tick_n    = tick_evt && !bus.restart;
    divider_n = (state_n == PLAY && bus.enable) ? cur_div_n : '0;
    note_on_n = (state_n == PLAY) && bus.enable && !cur_rest_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      presc     <= '0;
      remaining <= '0;
      step      <= '0;
      cur_div   <= '0;
      cur_rest  <= 1'b1;
      divider   <= '0;
      note_on   <= 1'b0;
      tick      <= 1'b0;
    end else begin
      state     <= state_n;
      presc     <= presc_n;
      remaining <= remaining_n;
      step      <= step_n;
      cur_div   <= cur_div_n;
      cur_rest  <= cur_rest_n;
      divider   <= divider_n;
      note_on   <= note_on_n;
      tick      <= tick_n;
    end
  end

  assign bus.divider = divider;
  assign bus.step    = step;
  assign bus.note_on = note_on;
  assign bus.tick    = tick;

endmodule
